bath_sequencer: RTL and testbench

Cycle sequencer for the bathroom appliance. It turns one-hot mode-button presses into a timed PREP → RUN → DRAIN program and drives the mode indication, heater and pump enables. It also implements the "press the same button again to stop" and "press another button to switch mode" behaviours. It sits between the button/debounce logic and the mode/lighting display and actuator outputs, and counts time only on a 1 Hz tick.

---
 rtl/bath_sequencer.sv | 178 +++++++++++++++++
 tb/tb_bath_sequencer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/bath_sequencer.sv
// Bathroom appliance cycle sequencer: one-hot mode presses drive a timed
// PREP -> RUN -> DRAIN program with heater/pump enables and a done pulse.
module bath_sequencer #(
  parameter logic [7:0] PREP_S  = 8'd3,
  parameter logic [7:0] RUN_A   = 8'd60,
  parameter logic [7:0] RUN_B   = 8'd30,
  parameter logic [7:0] RUN_C   = 8'd20,
  parameter logic [7:0] RUN_D   = 8'd10,
  parameter logic [7:0] DRAIN_S = 8'd4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       enable,
  input  logic [3:0] req,
  output logic [3:0] mode,
  output logic [1:0] state,
  output logic [7:0] remaining,
  output logic       heater,
  output logic       pump,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PREP  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] mode_q, mode_d;
  logic [7:0] remaining_q, remaining_d;
  logic [3:0] prev_req_q, prev_req_d;
  logic       done_q, done_d;

  logic [3:0] press_s;
  logic       valid_press_s;
  logic       same_mode_s;
  logic       last_tick_s;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [7:0] run_len(input logic [3:0] m);
    logic [7:0] len;
    case (m)
      4'b1000: len = RUN_A;
      4'b0100: len = RUN_B;
      4'b0010: len = RUN_C;
      4'b0001: len = RUN_D;
      default: len = RUN_A;
    endcase
    return len;
  endfunction

  // Next-state, mode, countdown and done computation
  always_comb begin
    press_s       = req & ~prev_req_q;
    valid_press_s = enable && is_onehot(press_s);
    same_mode_s   = (press_s == mode_q);
    last_tick_s   = (remaining_q == 8'd1);

    state_d     = state_q;
    mode_d      = mode_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    // prev_req keeps following req even during abort so a held button stays inert
    prev_req_d  = req;

    if (!enable) begin
      state_d     = S_IDLE;
      mode_d      = 4'd0;
      remaining_d = 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid_press_s) begin
            state_d     = S_PREP;
            mode_d      = press_s;
            remaining_d = PREP_S;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_PREP: begin
          if (valid_press_s) begin
            if (same_mode_s) begin
              state_d     = S_DRAIN;
              remaining_d = DRAIN_S;
            end else begin
              mode_d      = press_s;
              remaining_d = PREP_S;
            end
          end else if (tick) begin
            if (last_tick_s) begin
              state_d     = S_RUN;
              remaining_d = run_len(mode_q);
            end else begin
              remaining_d = remaining_q - 8'd1;
            end
          end else begin
            state_d = S_PREP;
          end
        end
        S_RUN: begin
          if (valid_press_s) begin
            if (same_mode_s) begin
              state_d     = S_DRAIN;
              remaining_d = DRAIN_S;
            end else begin
              state_d     = S_PREP;
              mode_d      = press_s;
              remaining_d = PREP_S;
            end
          end else if (tick) begin
            if (last_tick_s) begin
              state_d     = S_DRAIN;
              remaining_d = DRAIN_S;
            end else begin
              remaining_d = remaining_q - 8'd1;
            end
          end else begin
            state_d = S_RUN;
          end
        end
        S_DRAIN: begin
          // Presses are deliberately ignored while draining
          if (tick) begin
            if (last_tick_s) begin
              state_d     = S_IDLE;
              mode_d      = 4'd0;
              remaining_d = 8'd0;
              done_d      = 1'b1;
            end else begin
              remaining_d = remaining_q - 8'd1;
            end
          end else begin
            state_d = S_DRAIN;
          end
        end
        default: begin
          state_d     = S_IDLE;
          mode_d      = 4'd0;
          remaining_d = 8'd0;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= 4'd0;
      remaining_q <= 8'd0;
      prev_req_q  <= 4'b1111;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      remaining_q <= remaining_d;
      prev_req_q  <= prev_req_d;
      done_q      <= done_d;
    end
  end

  assign mode      = mode_q;
  assign state     = state_q;
  assign remaining = remaining_q;
  assign done      = done_q;
  assign heater    = (state_q == S_PREP) || (state_q == S_RUN);
  assign pump      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_bath_sequencer.sv
// Scoreboard bench for bath_sequencer: directed per-cycle vectors push expected
// outputs; a monitor pops and compares one entry after every clock edge.
module tb_bath_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] mode;
  logic [1:0] state;
  logic [7:0] remaining;
  logic       heater, pump, busy, done;

  typedef struct {
    logic [1:0] st;
    logic [3:0] md;
    logic [7:0] rm;
    logic       dn;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;

  bath_sequencer dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .enable(enable), .req(req),
    .mode(mode), .state(state), .remaining(remaining),
    .heater(heater), .pump(pump), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL vec%0d %s: got %0h expected %0h", vectors, nm, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest expectation after each edge
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      chk("state", {6'd0, state}, {6'd0, e.st});
      chk("mode", {4'd0, mode}, {4'd0, e.md});
      chk("remaining", remaining, e.rm);
      chk("done", {7'd0, done}, {7'd0, e.dn});
      chk("heater", {7'd0, heater}, {7'd0, (e.st == 2'd1) || (e.st == 2'd2)});
      chk("pump", {7'd0, pump}, {7'd0, (e.st == 2'd2) || (e.st == 2'd3)});
      chk("busy", {7'd0, busy}, {7'd0, e.st != 2'd0});
    end
  end

  task automatic push(input logic [1:0] st, input logic [3:0] md, input logic [7:0] rm, input logic dn);
    exp_t x;
    x.st = st; x.md = md; x.rm = rm; x.dn = dn;
    sb.push_back(x);
  endtask

  task automatic cyc(input logic [3:0] r, input logic t, input logic en,
                     input logic [1:0] st, input logic [3:0] md, input logic [7:0] rm, input logic dn);
    @(negedge clk);
    rst_n = 1'b1; req = r; tick = t; enable = en;
    push(st, md, rm, dn);
  endtask

  task automatic rst_cyc(input logic [3:0] r);
    @(negedge clk);
    rst_n = 1'b0; req = r; tick = 1'b0; enable = 1'b1;
    push(2'd0, 4'd0, 8'd0, 1'b0);
  endtask

  initial begin
    // Reset with button held: nothing starts after release of reset
    rst_cyc(4'b0001);
    rst_cyc(4'b0001);
    cyc(4'b0001, 1'b0, 1'b1, 2'd0, 4'd0, 8'd0, 1'b0);
    cyc(4'b0001, 1'b1, 1'b1, 2'd0, 4'd0, 8'd0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b1, 2'd0, 4'd0, 8'd0, 1'b0);

    // Normal program, mode D
    cyc(4'b0001, 1'b0, 1'b1, 2'd1, 4'b0001, 8'd3, 1'b0);
    cyc(4'b0001, 1'b0, 1'b1, 2'd1, 4'b0001, 8'd3, 1'b0);
    cyc(4'b0001, 1'b1, 1'b1, 2'd1, 4'b0001, 8'd2, 1'b0);
    cyc(4'b0000, 1'b1, 1'b1, 2'd1, 4'b0001, 8'd1, 1'b0);
    cyc(4'b0000, 1'b1, 1'b1, 2'd2, 4'b0001, 8'd10, 1'b0);
    for (int k = 9; k >= 1; k--) cyc(4'b0000, 1'b1, 1'b1, 2'd2, 4'b0001, 8'(k), 1'b0);
    cyc(4'b0000, 1'b1, 1'b1, 2'd3, 4'b0001, 8'd4, 1'b0);
    cyc(4'b0001, 1'b0, 1'b1, 2'd3, 4'b0001, 8'd4, 1'b0);
    cyc(4'b0000, 1'b0, 1'b1, 2'd3, 4'b0001, 8'd4, 1'b0);
    for (int k = 3; k >= 1; k--) cyc(4'b0000, 1'b1, 1'b1, 2'd3, 4'b0001, 8'(k), 1'b0);
    cyc(4'b0000, 1'b1, 1'b1, 2'd0, 4'd0, 8'd0, 1'b1);
    cyc(4'b0000, 1'b0, 1'b1, 2'd0, 4'd0, 8'd0, 1'b0);

    // Second press of same button in RUN at remaining=7 stops into DRAIN
    cyc(4'b0001, 1'b0, 1'b1, 2'd1, 4'b0001, 8'd3, 1'b0);
    cyc(4'b0000, 1'b1, 1'b1, 2'd1, 4'b0001, 8'd2, 1'b0);
    cyc(4'b0000, 1'b1, 1'b1, 2'd1, 4'b0001, 8'd1, 1'b0);
    cyc(4'b0000, 1'b1, 1'b1, 2'd2, 4'b0001, 8'd10, 1'b0);
    for (int k = 9; k >= 7; k--) cyc(4'b0000, 1'b1, 1'b1, 2'd2, 4'b0001, 8'(k), 1'b0);
    cyc(4'b0001, 1'b0, 1'b1, 2'd3, 4'b0001, 8'd4, 1'b0);
    cyc(4'b0000, 1'b0, 1'b1, 2'd3, 4'b0001, 8'd4, 1'b0);
    for (int k = 3; k >= 1; k--) cyc(4'b0000, 1'b1, 1'b1, 2'd3, 4'b0001, 8'(k), 1'b0);
    cyc(4'b0000, 1'b1, 1'b1, 2'd0, 4'd0, 8'd0, 1'b1);

    // Mode A to B switch from RUN, press colliding with a tick reloads PREP
    cyc(4'b1000, 1'b0, 1'b1, 2'd1, 4'b1000, 8'd3, 1'b0);
    cyc(4'b0000, 1'b1, 1'b1, 2'd1, 4'b1000, 8'd2, 1'b0);
    cyc(4'b0000, 1'b1, 1'b1, 2'd1, 4'b1000, 8'd1, 1'b0);
    cyc(4'b0000, 1'b1, 1'b1, 2'd2, 4'b1000, 8'd60, 1'b0);
    cyc(4'b0000, 1'b1, 1'b1, 2'd2, 4'b1000, 8'd59, 1'b0);
    cyc(4'b0100, 1'b1, 1'b1, 2'd1, 4'b0100, 8'd3, 1'b0);
    cyc(4'b0000, 1'b1, 1'b1, 2'd1, 4'b0100, 8'd2, 1'b0);
    cyc(4'b0110, 1'b0, 1'b1, 2'd1, 4'b0100, 8'd2, 1'b0);
    cyc(4'b0000, 1'b1, 1'b1, 2'd1, 4'b0100, 8'd1, 1'b0);
    cyc(4'b0000, 1'b1, 1'b1, 2'd2, 4'b0100, 8'd30, 1'b0);
    cyc(4'b0110, 1'b1, 1'b1, 2'd2, 4'b0100, 8'd29, 1'b0);
    cyc(4'b0000, 1'b0, 1'b1, 2'd2, 4'b0100, 8'd29, 1'b0);

    // Abort mid-RUN, then raise enable with a button held
    cyc(4'b0000, 1'b1, 1'b0, 2'd0, 4'd0, 8'd0, 1'b0);
    cyc(4'b0010, 1'b0, 1'b0, 2'd0, 4'd0, 8'd0, 1'b0);
    cyc(4'b0010, 1'b0, 1'b1, 2'd0, 4'd0, 8'd0, 1'b0);
    cyc(4'b0010, 1'b1, 1'b1, 2'd0, 4'd0, 8'd0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b1, 2'd0, 4'd0, 8'd0, 1'b0);

    // PREP: different-mode press reloads, same-mode press drains; reset mid-DRAIN
    cyc(4'b0100, 1'b0, 1'b1, 2'd1, 4'b0100, 8'd3, 1'b0);
    cyc(4'b0000, 1'b1, 1'b1, 2'd1, 4'b0100, 8'd2, 1'b0);
    cyc(4'b0010, 1'b0, 1'b1, 2'd1, 4'b0010, 8'd3, 1'b0);
    cyc(4'b0000, 1'b0, 1'b1, 2'd1, 4'b0010, 8'd3, 1'b0);
    cyc(4'b0010, 1'b0, 1'b1, 2'd3, 4'b0010, 8'd4, 1'b0);
    cyc(4'b0000, 1'b1, 1'b1, 2'd3, 4'b0010, 8'd3, 1'b0);
    rst_cyc(4'b0000);
    cyc(4'b0000, 1'b1, 1'b1, 2'd0, 4'd0, 8'd0, 1'b0);
    cyc(4'b0000, 1'b1, 1'b1, 2'd0, 4'd0, 8'd0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain_queue: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
